// File: rtl/video_frame_gate.sv
// Frame-aligned start/stop gate, frame decimator and geometry checker for a 4-pixel/beat AXI4-Stream video feed.
// Optional macro VIDEO_GATE_ERR_CNT_EN adds saturating err_sof_cnt / err_eol_cnt outputs.
module video_frame_gate #(
    parameter int DATA_W  = 96,
    parameter int H_BEATS = 16,
    parameter int V_LINES = 64,
    parameter int CNT_W   = 12,
    parameter int SKIP_W  = 4
) (
    input  logic              s_axis_video_aclk,
    input  logic              s_axis_video_areset,
    input  logic [DATA_W-1:0] VIDEO_IN_tdata,
    input  logic              VIDEO_IN_tvalid,
    output logic              VIDEO_IN_tready,
    input  logic              VIDEO_IN_tuser,
    input  logic              VIDEO_IN_tlast,
    output logic [DATA_W-1:0] VIDEO_OUT_tdata,
    output logic              VIDEO_OUT_tvalid,
    input  logic              VIDEO_OUT_tready,
    output logic              VIDEO_OUT_tuser,
    output logic              VIDEO_OUT_tlast,
    input  logic              start,
    input  logic              stop,
    input  logic [SKIP_W-1:0] frame_skip,
    output logic              busy,
    output logic [15:0]       frame_count,
    output logic              err_sof,
    output logic              err_eol
`ifdef VIDEO_GATE_ERR_CNT_EN
    ,
    output logic [15:0]       err_sof_cnt,
    output logic [15:0]       err_eol_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, PASS, DROP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  beat;
    logic [CNT_W-1:0]  line;
    logic [SKIP_W-1:0] skip_cnt;
    logic              stop_pending;

    logic              in_frame;
    logic              at_origin;
    logic              beat_last;
    logic              line_last;
    logic              stop_eff;
    logic              sof_wait;
    logic              sof_err;
    logic              take_sof;
    logic              pass_now;
    logic              pass_sel;
    logic              hs;
    logic [SKIP_W-1:0] skip_next;

    assign in_frame  = (state == PASS) || (state == DROP);
    assign at_origin = (beat == '0) && (line == '0);
    assign beat_last = (beat == CNT_W'(H_BEATS - 1));
    assign line_last = (line == CNT_W'(V_LINES - 1));
    assign stop_eff  = stop_pending | stop;
    assign pass_now  = (skip_cnt == '0);
    assign skip_next = (skip_cnt >= frame_skip) ? '0 : skip_cnt + 1'b1;

    // A misplaced SOF inside a frame restarts the frame on that very beat unless a stop is outstanding.
    assign sof_wait = (state == WAIT_SOF) && VIDEO_IN_tuser && !stop;
    assign sof_err  = in_frame && VIDEO_IN_tuser && !at_origin;
    assign take_sof = sof_wait || (sof_err && !stop_eff);
    assign pass_sel = take_sof ? pass_now : ((state == PASS) && !sof_err);

    // Zero-latency datapath: the gate only chooses between forwarding and draining.
    assign VIDEO_OUT_tdata  = VIDEO_IN_tdata;
    assign VIDEO_OUT_tuser  = VIDEO_IN_tuser;
    assign VIDEO_OUT_tlast  = VIDEO_IN_tlast;
    assign VIDEO_OUT_tvalid = pass_sel & VIDEO_IN_tvalid;
    assign VIDEO_IN_tready  = pass_sel ? VIDEO_OUT_tready : 1'b1;
    assign hs               = VIDEO_IN_tvalid & VIDEO_IN_tready;
    assign busy             = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge s_axis_video_aclk or posedge s_axis_video_areset) begin
        if (s_axis_video_areset) begin
            state        <= IDLE;
            beat         <= '0;
            line         <= '0;
            skip_cnt     <= '0;
            stop_pending <= 1'b0;
            frame_count  <= '0;
            err_sof      <= 1'b0;
            err_eol      <= 1'b0;
        end else begin
            err_sof <= 1'b0;
            err_eol <= 1'b0;
            case (state)
                IDLE: begin
                    stop_pending <= 1'b0;
                    if (start && !stop) state <= WAIT_SOF;
                end
                WAIT_SOF: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (hs && VIDEO_IN_tuser) begin
                        state    <= pass_now ? PASS : DROP;
                        skip_cnt <= skip_next;
                        beat     <= CNT_W'(1);
                        line     <= '0;
                        if (pass_now) frame_count <= frame_count + 16'd1;
                    end
                end
                PASS, DROP: begin
                    if (stop) stop_pending <= 1'b1;
                    if (hs) begin
                        if (sof_err) begin
                            err_sof <= 1'b1;
                            if (stop_eff) begin
                                state <= IDLE;
                            end else begin
                                state    <= pass_now ? PASS : DROP;
                                skip_cnt <= skip_next;
                                beat     <= CNT_W'(1);
                                line     <= '0;
                                if (pass_now) frame_count <= frame_count + 16'd1;
                            end
                        end else begin
                            // A missing tlast still closes the line so geometry stays locked to the frame.
                            if (VIDEO_IN_tlast != beat_last) err_eol <= 1'b1;
                            if (VIDEO_IN_tlast || beat_last) begin
                                beat <= '0;
                                if (line_last) begin
                                    line  <= '0;
                                    state <= stop_eff ? IDLE : WAIT_SOF;
                                end else begin
                                    line <= line + 1'b1;
                                end
                            end else begin
                                beat <= beat + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VIDEO_GATE_ERR_CNT_EN
    always_ff @(posedge s_axis_video_aclk or posedge s_axis_video_areset) begin
        if (s_axis_video_areset) begin
            err_sof_cnt <= '0;
            err_eol_cnt <= '0;
        end else if ((state == IDLE) && start && !stop) begin
            err_sof_cnt <= '0;
            err_eol_cnt <= '0;
        end else begin
            if (err_sof && (err_sof_cnt != 16'hFFFF)) err_sof_cnt <= err_sof_cnt + 16'd1;
            if (err_eol && (err_eol_cnt != 16'hFFFF)) err_eol_cnt <= err_eol_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_video_frame_gate.sv
// Scoreboard bench for video_frame_gate: expected beats queued at the source, compared against observed output beats.
module tb_video_frame_gate;

    localparam int DATA_W  = 96;
    localparam int H_BEATS = 16;
    localparam int V_LINES = 64;
    localparam int SKIP_W  = 4;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              user;
        logic              last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] in_tdata = '0;
    logic              in_tvalid = 1'b0;
    logic              in_tready;
    logic              in_tuser = 1'b0;
    logic              in_tlast = 1'b0;
    logic [DATA_W-1:0] out_tdata;
    logic              out_tvalid;
    logic              out_tready = 1'b1;
    logic              out_tuser;
    logic              out_tlast;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [SKIP_W-1:0] frame_skip = '0;
    logic              busy;
    logic [15:0]       frame_count;
    logic              err_sof;
    logic              err_eol;
`ifdef VIDEO_GATE_ERR_CNT_EN
    logic [15:0]       err_sof_cnt;
    logic [15:0]       err_eol_cnt;
`endif

    beat_t sb_q[$];
    beat_t obs_q[$];
    int    checks = 0;
    int    errors = 0;
    int    sof_seen = 0;
    int    eol_seen = 0;
    int    mirror_bad = 0;
    int    drop_stall = 0;
    bit    mirror_en = 1'b0;
    bit    toggle_mode = 1'b0;

    always #5 clk = ~clk;

    video_frame_gate dut (
        .s_axis_video_aclk   (clk),
        .s_axis_video_areset (rst),
        .VIDEO_IN_tdata      (in_tdata),
        .VIDEO_IN_tvalid     (in_tvalid),
        .VIDEO_IN_tready     (in_tready),
        .VIDEO_IN_tuser      (in_tuser),
        .VIDEO_IN_tlast      (in_tlast),
        .VIDEO_OUT_tdata     (out_tdata),
        .VIDEO_OUT_tvalid    (out_tvalid),
        .VIDEO_OUT_tready    (out_tready),
        .VIDEO_OUT_tuser     (out_tuser),
        .VIDEO_OUT_tlast     (out_tlast),
        .start               (start),
        .stop                (stop),
        .frame_skip          (frame_skip),
        .busy                (busy),
        .frame_count         (frame_count),
        .err_sof             (err_sof),
        .err_eol             (err_eol)
`ifdef VIDEO_GATE_ERR_CNT_EN
        ,
        .err_sof_cnt         (err_sof_cnt),
        .err_eol_cnt         (err_eol_cnt)
`endif
    );

    // Output monitor: records accepted output beats and error pulses on the inactive edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_tvalid && out_tready) obs_q.push_back({out_tdata, out_tuser, out_tlast});
            if (err_sof) sof_seen++;
            if (err_eol) eol_seen++;
            if (mirror_en && in_tvalid && (in_tready !== out_tready)) mirror_bad++;
        end
    end

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r;
    endfunction

    task automatic send_beat(input logic [DATA_W-1:0] d, input logic u, input logic l, input bit fwd);
        bit got;
        in_tdata  = d;
        in_tuser  = u;
        in_tlast  = l;
        in_tvalid = 1'b1;
        if (fwd) sb_q.push_back({d, u, l});
        got = 1'b0;
        for (int c = 0; c < 64 && !got; c++) begin
            @(negedge clk);
            got = in_tready;
            if (!fwd && !in_tready) drop_stall++;
            @(posedge clk);
            #1;
            if (toggle_mode) out_tready = ~out_tready;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: in_tready stayed 0, required 1 within 64 cycles");
        end
    endtask

    task automatic send_frame(input bit fwd, input int lines, input int extra, input int short_line,
                              input int stop_line);
        int n;
        for (int ln = 0; ln < lines; ln++) begin
            n = (ln == short_line) ? 8 : H_BEATS;
            for (int b = 0; b < n; b++) begin
                if (ln == stop_line && b == 0) stop = 1'b1;
                send_beat(rand_data(), (ln == 0 && b == 0), (b == n - 1), fwd);
                stop = 1'b0;
            end
        end
        for (int b = 0; b < extra; b++) send_beat(rand_data(), 1'b0, 1'b0, fwd);
    endtask

    task automatic wait_cycles(input int n);
        in_tvalid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        in_tvalid = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain_scoreboard(input string name);
        beat_t e;
        beat_t o;
        while (sb_q.size() > 0 && obs_q.size() > 0) begin
            e = sb_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s_beat: got %h required %h", name, o, e);
            end
        end
        checks++;
        if (sb_q.size() != 0 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL %s_beat_count: %0d unmatched observed, %0d unmatched expected (required 0/0)",
                     name, obs_q.size(), sb_q.size());
        end
        sb_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        in_tvalid = 1'b1;
        in_tuser  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_tvalid !== 1'b0) begin errors++; $display("FAIL reset_out_tvalid: got %b required 0", out_tvalid); end
        checks++;
        if (in_tready !== 1'b1) begin errors++; $display("FAIL reset_in_tready: got %b required 1", in_tready); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++;
        if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame_count: got %0d required 0", frame_count); end
        checks++;
        if (err_sof !== 1'b0 || err_eol !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got sof=%b eol=%b required 0/0", err_sof, err_eol);
        end
        in_tvalid = 1'b0;
        in_tuser  = 1'b0;
        rst = 1'b0;
        wait_cycles(2);
    endtask

    task automatic test_pass_frames();
        frame_skip = 4'd0;
        start_pulse();
        for (int f = 0; f < 3; f++) send_frame(1'b1, V_LINES, 0, -1, -1);
        wait_cycles(3);
        drain_scoreboard("pass");
        checks++;
        if (frame_count !== 16'd3) begin errors++; $display("FAIL pass_frame_count: got %0d required 3", frame_count); end
        checks++;
        if (sof_seen != 0 || eol_seen != 0) begin
            errors++;
            $display("FAIL pass_err_pulses: got sof=%0d eol=%0d required 0/0", sof_seen, eol_seen);
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL pass_busy: got %b required 1", busy); end
    endtask

    task automatic test_skip();
        frame_skip = 4'd2;
        for (int f = 0; f < 6; f++) send_frame((f % 3) == 0, V_LINES, 0, -1, -1);
        wait_cycles(3);
        drain_scoreboard("skip");
        checks++;
        if (frame_count !== 16'd5) begin errors++; $display("FAIL skip_frame_count: got %0d required 5", frame_count); end
        checks++;
        if (drop_stall != 0) begin errors++; $display("FAIL skip_drain_ready: got %0d stalled cycles required 0", drop_stall); end
        frame_skip = 4'd0;
    endtask

    task automatic test_stop();
        send_frame(1'b1, V_LINES, 0, -1, 10);
        wait_cycles(2);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b required 0", busy); end
        send_frame(1'b0, V_LINES, 0, -1, -1);
        wait_cycles(2);
        drain_scoreboard("stop");
        checks++;
        if (frame_count !== 16'd6) begin errors++; $display("FAIL stop_frame_count: got %0d required 6", frame_count); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL stop_idle_after: got busy=%b required 0", busy); end
    endtask

    task automatic test_eol_err();
        int sof0 = sof_seen;
        int eol0 = eol_seen;
        start_pulse();
        send_frame(1'b1, V_LINES, 0, 5, -1);
        send_frame(1'b1, V_LINES, 0, -1, -1);
        wait_cycles(3);
        drain_scoreboard("eol");
        checks++;
        if (eol_seen - eol0 != 1) begin errors++; $display("FAIL eol_pulses: got %0d required 1", eol_seen - eol0); end
        checks++;
        if (sof_seen - sof0 != 0) begin errors++; $display("FAIL eol_sof_pulses: got %0d required 0", sof_seen - sof0); end
        checks++;
        if (frame_count !== 16'd8) begin errors++; $display("FAIL eol_frame_count: got %0d required 8", frame_count); end
    endtask

    task automatic test_sof_err();
        int sof0 = sof_seen;
        int eol0 = eol_seen;
        send_frame(1'b1, 20, 3, -1, -1);
        send_frame(1'b1, V_LINES, 0, -1, -1);
        wait_cycles(3);
        drain_scoreboard("sof");
        checks++;
        if (sof_seen - sof0 != 1) begin errors++; $display("FAIL sof_pulses: got %0d required 1", sof_seen - sof0); end
        checks++;
        if (eol_seen - eol0 != 0) begin errors++; $display("FAIL sof_eol_pulses: got %0d required 0", eol_seen - eol0); end
        checks++;
        if (frame_count !== 16'd10) begin errors++; $display("FAIL sof_frame_count: got %0d required 10", frame_count); end
`ifdef VIDEO_GATE_ERR_CNT_EN
        checks++;
        if (err_sof_cnt !== 16'd1 || err_eol_cnt !== 16'd1) begin
            errors++;
            $display("FAIL err_cnt: got sof=%0d eol=%0d required 1/1", err_sof_cnt, err_eol_cnt);
        end
`endif
    endtask

    task automatic test_backpressure();
        toggle_mode = 1'b1;
        mirror_en   = 1'b1;
        send_frame(1'b1, V_LINES, 0, -1, -1);
        mirror_en   = 1'b0;
        toggle_mode = 1'b0;
        out_tready  = 1'b1;
        wait_cycles(3);
        drain_scoreboard("bp");
        checks++;
        if (mirror_bad != 0) begin errors++; $display("FAIL bp_ready_mirror: got %0d mismatched cycles required 0", mirror_bad); end
        checks++;
        if (frame_count !== 16'd11) begin errors++; $display("FAIL bp_frame_count: got %0d required 11", frame_count); end
    endtask

    task automatic test_reset_mid();
        start_pulse();
        send_frame(1'b1, 2, 5, -1, -1);
        in_tdata  = rand_data();
        in_tuser  = 1'b0;
        in_tlast  = 1'b0;
        in_tvalid = 1'b1;
        #2;
        checks++;
        if (out_tvalid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_tvalid: got %b required 1", out_tvalid); end
        rst = 1'b1;
        #1;
        checks++;
        if (out_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid: got %b required 0", out_tvalid); end
        checks++;
        if (busy !== 1'b0 || in_tready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_idle: got busy=%b in_tready=%b required 0/1", busy, in_tready);
        end
        checks++;
        if (frame_count !== 16'd0) begin errors++; $display("FAIL rstmid_frame_count: got %0d required 0", frame_count); end
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(1);
        send_frame(1'b0, V_LINES, 0, -1, -1);
        wait_cycles(2);
        checks++;
        if (frame_count !== 16'd0) begin errors++; $display("FAIL rstmid_no_start: got %0d required 0", frame_count); end
        start_pulse();
        send_frame(1'b1, V_LINES, 0, -1, -1);
        wait_cycles(3);
        drain_scoreboard("rstmid");
        checks++;
        if (frame_count !== 16'd1) begin errors++; $display("FAIL rstmid_restart_count: got %0d required 1", frame_count); end
    endtask

    initial begin
        test_reset();
        test_pass_frames();
        test_skip();
        test_stop();
        test_eol_err();
        test_sof_err();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
